// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle control unit.
// Holds opcode/funct constants, the FSM state encoding, the extender
// (EOp) and ALU op codes, datapath mux select codes and the one-hot
// instruction class produced by mc_decode.
package mc_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Immediate extender modes
  localparam logic [1:0] EXT_SIGN = 2'd0;
  localparam logic [1:0] EXT_ZERO = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;
  localparam logic [1:0] EXT_BR   = 2'd3;

  // ALU operations
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;
  localparam logic [2:0] ALU_PASSB = 3'd3;

  // PC source select
  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // GRF destination and write-data selects
  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;

  // One-hot instruction class; exactly one field is set for any encoding
  typedef struct packed {
    logic rtype_addu;
    logic rtype_subu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic illegal;
  } instr_class_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier.
// Ports:
//   instr - current IR contents
//   cls   - one-hot instruction class (illegal set for any unsupported encoding)
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_t cls
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  // Anything not explicitly recognised falls through to illegal, which
  // keeps the class one-hot for every possible encoding.
  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADDU)      cls.rtype_addu = 1'b1;
        else if (funct == FN_SUBU) cls.rtype_subu = 1'b1;
        else                       cls.illegal    = 1'b1;
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_J:    cls.j   = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for the MIPS-subset datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives the datapath controls.
// Ports:
//   clk, reset         - core clock, synchronous active-high reset
//   instr, zero        - IR contents and ALU equality flag
//   ir_we, pc_we       - IR load and PC write enables
//   pc_src             - PC source (PC+4 / branch target / jump)
//   reg_we, reg_dst    - GRF write enable and destination select
//   wd_sel             - GRF write-data select (ALU / DM)
//   alu_b_sel, EOp     - ALU B operand select and extender mode
//   alu_op             - ALU operation
//   mem_we             - DM write enable
//   state              - current FSM state (debug)
//   illegal            - pulse in DECODE on an unsupported encoding
//   retired            - completed-instruction counter
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_b_sel,
  output logic [1:0]       EOp,
  output logic [2:0]       alu_op,
  output logic             mem_we,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t       state_q;
  state_t       state_nxt;
  instr_class_t cls;
  logic         retire;
  logic         ir_we_c;
  logic         pc_we_c;
  logic         reg_we_c;
  logic         mem_we_c;
  logic         illegal_c;

  mc_decode u_decode (
    .instr (instr),
    .cls   (cls)
  );

  assign state = state_q;

  // Sequencing and write controls. retire marks the final cycle of each
  // instruction; the counter picks it up at the closing edge.
  always_comb begin
    state_nxt = S_FETCH;
    retire    = 1'b0;
    ir_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    pc_src    = PC_SEQ;
    reg_we_c  = 1'b0;
    reg_dst   = DST_RT;
    wd_sel    = WD_ALU;
    mem_we_c  = 1'b0;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_we_c   = 1'b1;
        pc_we_c   = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (cls.j) begin
          pc_we_c = 1'b1;
          pc_src  = PC_JUMP;
          retire  = 1'b1;
        end else if (cls.illegal) begin
          illegal_c = 1'b1;
          retire    = 1'b1;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls.beq) begin
          pc_src  = PC_BRANCH;
          pc_we_c = zero;
          retire  = 1'b1;
        end else if (cls.lw || cls.sw) begin
          state_nxt = S_MEM;
        end else if (cls.rtype_addu || cls.rtype_subu || cls.ori || cls.lui) begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (cls.sw) begin
          mem_we_c = 1'b1;
          retire   = 1'b1;
        end else if (cls.lw) begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        // Gated by class so a corrupted path can never write the GRF.
        if (cls.rtype_addu || cls.rtype_subu) begin
          reg_we_c = 1'b1;
          reg_dst  = DST_RD;
          retire   = 1'b1;
        end else if (cls.ori || cls.lui) begin
          reg_we_c = 1'b1;
          retire   = 1'b1;
        end else if (cls.lw) begin
          reg_we_c = 1'b1;
          wd_sel   = WD_MEM;
          retire   = 1'b1;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // ALU/extender controls are set from EXEC and held through MEM and WB
  // so address and result paths stay stable without extra registers.
  always_comb begin
    EOp       = EXT_SIGN;
    alu_op    = ALU_ADD;
    alu_b_sel = 1'b0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      if (cls.rtype_subu) begin
        alu_op = ALU_SUB;
      end else if (cls.ori) begin
        EOp       = EXT_ZERO;
        alu_b_sel = 1'b1;
        alu_op    = ALU_OR;
      end else if (cls.lui) begin
        EOp       = EXT_LUI;
        alu_b_sel = 1'b1;
        alu_op    = ALU_PASSB;
      end else if (cls.lw || cls.sw) begin
        alu_b_sel = 1'b1;
      end else if (cls.beq) begin
        EOp    = EXT_BR;
        alu_op = ALU_SUB;
      end
    end
  end

  // Reset masks every architectural write so an aborted instruction
  // leaves no side effects.
  assign ir_we   = ir_we_c   & ~reset;
  assign pc_we   = pc_we_c   & ~reset;
  assign reg_we  = reg_we_c  & ~reset;
  assign mem_we  = mem_we_c  & ~reset;
  assign illegal = illegal_c & ~reset;

  // State register and retired counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      retired <= '0;
    end else begin
      state_q <= state_nxt;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl. Each issued instruction
// pushes its expected per-cycle control rows; a negedge monitor pops and
// compares them against the DUT outputs.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        ir_we, pc_we, reg_we, alu_b_sel, mem_we, illegal;
  logic [1:0]  pc_src, reg_dst, wd_sel, EOp;
  logic [2:0]  alu_op, state;
  logic [31:0] retired;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .zero      (zero),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .reg_we    (reg_we),
    .reg_dst   (reg_dst),
    .wd_sel    (wd_sel),
    .alu_b_sel (alu_b_sel),
    .EOp       (EOp),
    .alu_op    (alu_op),
    .mem_we    (mem_we),
    .state     (state),
    .illegal   (illegal),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic [1:0]  wd_sel;
    logic        bsel;
    logic [1:0]  eop;
    logic [2:0]  aluop;
    logic        mem_we;
    logic        ill;
    logic [31:0] ret;
  } row_t;

  typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_J, K_ILL} kind_t;

  row_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    ret_model = 0;
  int    cycle_cnt = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Classify an encoding from the instruction-set table
  function automatic kind_t kind_of(input logic [31:0] ins);
    case (ins[31:26])
      6'h00:   return (ins[5:0] == 6'h21) ? K_ADDU : (ins[5:0] == 6'h23) ? K_SUBU : K_ILL;
      6'h0D:   return K_ORI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h0F:   return K_LUI;
      6'h02:   return K_J;
      default: return K_ILL;
    endcase
  endfunction

  // Build a random encoding of the requested kind
  function automatic logic [31:0] rand_instr(input kind_t k);
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  op, fn;
    rs  = 5'($urandom);
    rt  = 5'($urandom);
    rd  = 5'($urandom);
    imm = 16'($urandom);
    case (k)
      K_ADDU: return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      K_SUBU: return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      K_ORI:  return {6'h0D, rs, rt, imm};
      K_LW:   return {6'h23, rs, rt, imm};
      K_SW:   return {6'h2B, rs, rt, imm};
      K_BEQ:  return {6'h04, rs, rt, imm};
      K_LUI:  return {6'h0F, 5'd0, rt, imm};
      K_J:    return {6'h02, 26'($urandom)};
      default: begin
        if ($urandom_range(0, 1) == 0) begin
          fn = 6'($urandom);
          if (fn == 6'h21 || fn == 6'h23) fn = 6'h20;
          return {6'h00, rs, rt, rd, 5'd0, fn};
        end
        op = 6'($urandom);
        while (op == 6'h00 || op == 6'h0D || op == 6'h23 || op == 6'h2B ||
               op == 6'h04 || op == 6'h0F || op == 6'h02)
          op = 6'($urandom);
        return {op, rs, rt, imm};
      end
    endcase
  endfunction

  // Extender/ALU settings each instruction uses from its execute step on
  function automatic row_t with_alu(input row_t r, input kind_t k);
    row_t o;
    o = r;
    case (k)
      K_ADDU: begin o.eop = 2'd0; o.bsel = 1'b0; o.aluop = 3'd0; end
      K_SUBU: begin o.eop = 2'd0; o.bsel = 1'b0; o.aluop = 3'd1; end
      K_ORI:  begin o.eop = 2'd1; o.bsel = 1'b1; o.aluop = 3'd2; end
      K_LUI:  begin o.eop = 2'd2; o.bsel = 1'b1; o.aluop = 3'd3; end
      K_LW, K_SW: begin o.eop = 2'd0; o.bsel = 1'b1; o.aluop = 3'd0; end
      K_BEQ:  begin o.eop = 2'd3; o.bsel = 1'b0; o.aluop = 3'd1; end
      default: ;
    endcase
    return o;
  endfunction

  // Reference model: per-instruction list of cycles and their controls
  task automatic model_push(input logic [31:0] ins, input logic z, output int n);
    kind_t k;
    row_t  r;
    k = kind_of(ins);
    n = 0;
    r = '0; r.ret = ret_model; r.st = 3'd0; r.ir_we = 1'b1; r.pc_we = 1'b1;
    exp_q.push_back(r); n++;
    r = '0; r.ret = ret_model; r.st = 3'd1;
    if (k == K_J) begin r.pc_we = 1'b1; r.pc_src = 2'd2; end
    if (k == K_ILL) r.ill = 1'b1;
    exp_q.push_back(r); n++;
    if (k != K_J && k != K_ILL) begin
      r = '0; r.ret = ret_model; r.st = 3'd2;
      r = with_alu(r, k);
      if (k == K_BEQ) begin r.pc_src = 2'd1; r.pc_we = z; end
      exp_q.push_back(r); n++;
      if (k == K_LW || k == K_SW) begin
        r = '0; r.ret = ret_model; r.st = 3'd3;
        r = with_alu(r, k);
        if (k == K_SW) r.mem_we = 1'b1;
        exp_q.push_back(r); n++;
      end
      if (k != K_BEQ && k != K_SW) begin
        r = '0; r.ret = ret_model; r.st = 3'd4;
        r = with_alu(r, k);
        r.reg_we  = 1'b1;
        r.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
        r.wd_sel  = (k == K_LW) ? 2'd1 : 2'd0;
        exp_q.push_back(r); n++;
      end
    end
    ret_model++;
  endtask

  // Issue one instruction; entered and left just after the edge into FETCH
  task automatic applyStimulus(input logic [31:0] ins, input logic z);
    int n;
    model_push(ins, z, n);
    @(posedge clk); #1;
    instr = ins;
    zero  = z;
    repeat (n - 1) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    row_t e, a;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, ir_we, pc_we, pc_src, reg_we, reg_dst, wd_sel, alu_b_sel,
           EOp, alu_op, mem_we, illegal, retired};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("[TB] FAIL row st=%0d: got st=%0d irwe=%b pcwe=%b pcsrc=%0d regwe=%b dst=%0d wd=%0d bsel=%b eop=%0d alu=%0d memwe=%b ill=%b ret=%0d, expected st=%0d irwe=%b pcwe=%b pcsrc=%0d regwe=%b dst=%0d wd=%0d bsel=%b eop=%0d alu=%0d memwe=%b ill=%b ret=%0d",
                 e.st, a.st, a.ir_we, a.pc_we, a.pc_src, a.reg_we, a.reg_dst, a.wd_sel, a.bsel,
                 a.eop, a.aluop, a.mem_we, a.ill, a.ret,
                 e.st, e.ir_we, e.pc_we, e.pc_src, e.reg_we, e.reg_dst, e.wd_sel, e.bsel,
                 e.eop, e.aluop, e.mem_we, e.ill, e.ret);
      end
    end
  end

  initial begin
    int c0;
    logic [31:0] r0;
    reset = 1'b1;
    instr = 32'h0022_1821;
    zero  = 1'b0;

    // Reset held for three cycles: no writes, state FETCH, counter cleared
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_writes", {ir_we, pc_we, reg_we, mem_we, illegal}, 32'd0);
      checkOutput("reset_state", state, 32'd0);
    end
    checkOutput("reset_retired", retired, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] directed sequence");
    applyStimulus(32'h0022_1821, 1'b0);
    checkOutput("addu_retired", retired, 32'd1);
    applyStimulus(32'h8C22_FFFC, 1'b1);
    applyStimulus(32'h1022_FFFF, 1'b1);
    applyStimulus(32'h1022_FFFF, 1'b0);
    checkOutput("beq_retired", retired, 32'd4);

    c0 = cycle_cnt;
    r0 = retired;
    applyStimulus(32'h3421_FFFF, 1'b0);
    applyStimulus(32'h3C01_1234, 1'b1);
    applyStimulus(32'hAC22_0008, 1'b0);
    applyStimulus(32'h0800_0010, 1'b1);
    checkOutput("seq_cycles", 32'(cycle_cnt - c0), 32'd14);
    checkOutput("seq_retired", retired - r0, 32'd4);

    applyStimulus(32'hFC00_0000, 1'b0);
    applyStimulus(32'h0022_1820, 1'b1);

    $display("[TB] random sequence");
    for (int i = 0; i < 300; i++) begin
      kind_t k;
      k = kind_t'($urandom_range(0, 8));
      applyStimulus(rand_instr(k), 1'($urandom));
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    checkOutput("retired_total", retired, 32'(ret_model));

    // Reset during MEM of sw aborts the store and clears the counter
    $display("[TB] reset during sw MEM");
    r0 = retired;
    @(posedge clk); #1;
    instr = 32'hAC22_0008;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("abort_in_mem", state, 32'd3);
    checkOutput("abort_memwe_before", mem_we, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort_memwe", mem_we, 32'd0);
    checkOutput("abort_ret_hold", retired, r0);
    @(posedge clk); #1;
    checkOutput("abort_ret_clear", retired, 32'd0);
    checkOutput("abort_state", state, 32'd0);
    checkOutput("abort_irwe_masked", ir_we, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("after_reset_fetch", {state, ir_we}, {29'd0, 3'd1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the single-issue MIPS-subset datapath. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, and drives the write enables and mux selects for the PC, IR, GRF and DM. It also supplies `EOp` to the immediate extender and the ALU op. It sits beside the datapath top, reads the IR contents and the ALU zero flag, and holds the only FSM in the core.

## Interface
Parameters:
- `CNT_W`, 32, width of retired-instruction counter

Ports:
- `clk`  in  1  core clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `instr`  in  32  current IR contents (stable from DECODE onward)
- `zero`  in  1  ALU equality flag, valid in EXEC
- `ir_we`  out  1  load IR from IM
- `pc_we`  out  1  PC write enable
- `pc_src`  out  2  0=PC+4, 1=branch target (ALU result), 2=jump {PC[31:28],instr[25:0],2'b00}
- `reg_we`  out  1  GRF write enable
- `reg_dst`  out  2  0=rt, 1=rd
- `wd_sel`  out  2  0=ALU result, 1=DM read data
- `alu_b_sel`  out  1  0=GRF rt data, 1=extender output
- `EOp`  out  2  extender mode: 0=sign, 1=zero, 2=imm<<16, 3=sign<<2
- `alu_op`  out  3  0=add, 1=sub, 2=or, 3=pass B
- `mem_we`  out  1  DM write enable
- `state`  out  3  current state (debug)
- `illegal`  out  1  1-cycle pulse in DECODE on an unrecognised encoding
- `retired`  out  CNT_W  count of completed instructions

## Operation
- Supported instructions: addu (op 000000, funct 100001), subu (000000/100011), ori (001101), lw (100011), sw (101011), beq (000100), lui (001111), j (000010).
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Any other encoding goes to FETCH next cycle.
- FETCH: `ir_we=1`, `pc_we=1`, `pc_src=0`. Next state is DECODE.
- DECODE:
  - j: `pc_we=1`, `pc_src=2`, retire, go to FETCH.
  - Illegal encoding: pulse `illegal`, retire as nop, go to FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - addu/subu: `alu_op` = add/sub, `alu_b_sel=0`.
  - ori: `EOp=1`, `alu_b_sel=1`, `alu_op=or`.
  - lui: `EOp=2`, `alu_b_sel=1`, `alu_op=pass B`.
  - lw/sw: `EOp=0`, `alu_b_sel=1`, `alu_op=add`.
  - beq: `alu_op=sub`, `EOp=3`, `pc_src=1`, `pc_we=zero`; retire and go to FETCH.
  - lw/sw go to MEM; all others go to WB.
- MEM:
  - sw: `mem_we=1`, retire, go to FETCH.
  - lw: go to WB.
- WB: `reg_we=1`, then retire and go to FETCH.
  - R-type: `reg_dst=1`, `wd_sel=0`.
  - ori/lui: `reg_dst=0`, `wd_sel=0`.
  - lw: `reg_dst=0`, `wd_sel=1`.
- `EOp`, `alu_op` and `alu_b_sel` hold their EXEC values through MEM and WB, so the datapath can recompute addresses without latches.
- Outputs are combinational in `state` and `instr` (and `zero`). Unlisted outputs are 0.
- `retired` increments by 1 in the last cycle of each instruction and wraps modulo 2^CNT_W.

## Timing
- Cycles per instruction: j=2, beq=3, illegal=2, addu/subu/ori/lui/sw=4, lw=5.
- Reset: while `reset`=1, all write enables (`ir_we`, `pc_we`, `reg_we`, `mem_we`) and `illegal` are forced 0. At the edge, `state` goes to FETCH and `retired` goes to 0.
  - First fetch occurs in the cycle after `reset` falls.
  - Reset mid-instruction aborts it with no write and no retire.
- `zero` is sampled only in EXEC of beq. Its value in other states is ignored.
- `instr` changes only on an `ir_we` edge. Decode must not use `instr` during FETCH except for the fixed FETCH outputs.
- Illegal encodings never assert `reg_we` or `mem_we`.

## Structure
- Package `mc_pkg` holds:
  - opcode/funct constants
  - state encodings
  - `EOp` codes (EXT_SIGN=0, EXT_ZERO=1, EXT_LUI=2, EXT_BR=3)
  - `alu_op` codes
- Sub-module `mc_decode` is combinational. Input `instr`. Outputs a one-hot instruction class (rtype_addu, rtype_subu, ori, lw, sw, beq, lui, j, illegal).
- `mc_ctrl` holds the state register, the retired counter and the output logic.

## Test plan
- Reset held 3 cycles, then released with IR = addu $3,$1,$2 (0x00221821):
  - States 0,1,2,4 then 0.
  - `reg_we=1`, `reg_dst=1` only in WB.
  - `retired`=1.
- lw $2,-4($1) (0x8C22FFFC):
  - 5 cycles.
  - `EOp=0`, `alu_b_sel=1` from EXEC through WB.
  - `wd_sel=1` in WB; `mem_we` never asserted.
- beq with `zero`=1, then with `zero`=0 (0x1022FFFF):
  - 3 cycles each; `EOp=3`, `pc_src=1`.
  - `pc_we` in EXEC equals `zero`; `retired` +1 each time.
- Sequence ori (0x3421FFFF), lui (0x3C011234), sw (0xAC220008), j (0x08000010):
  - `EOp` = 1, 2, 0 respectively in EXEC.
  - sw: `mem_we` only in MEM.
  - j: `pc_we=1`, `pc_src=2` in DECODE.
  - Total 14 cycles; `retired`=4.
- IR=0xFC000000 (illegal): `illegal` pulses in DECODE, no writes, back to FETCH after 2 cycles.
- `reset` asserted in MEM of sw: no `mem_we` that cycle, `retired` unchanged before the reset edge and 0 after it, `state`=0 next cycle.
